// File: rtl/panel_loader_pkg.sv
// rtl/panel_loader_pkg.sv - shared CPU definitions for the front-panel loader
// Purpose: loader state encoding, trace entry type codes and the default start PC.
// Ports: none (package).
package panel_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_SET,
    S_LPC_HI,
    S_LPC_LO,
    S_DATA_SET,
    S_DEP_HI,
    S_DEP_LO,
    S_PC_SET,
    S_PC_HI,
    S_PC_LO,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] TR_READ  = 2'b00;
  localparam logic [1:0] TR_FETCH = 2'b01;
  localparam logic [1:0] TR_WRITE = 2'b10;

  localparam logic [11:0] DEFAULT_START_PC = 12'o0200;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - show-ahead FIFO holding memory-bus trace entries
// Purpose: stores trace entries; head is visible whenever not empty, full
//          pushes are dropped unless a pop frees a slot the same clock.
// Ports: clk, rst (async active-low), push/push_data (write side),
//        pop (read side), head/empty (read view), overflow (sticky drop flag).
module trace_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same clock frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/panel_loader.sv
// rtl/panel_loader.sv - drives a CPU front panel to load an image, then traces the bus
// Purpose: accepts (addr, data, last) words, toggles the panel switches and buttons
//          to deposit each word, loads START_PC, sets RUN until the CPU halts, and
//          records memory-bus transfers seen while running.
// Ports: clk, rst (async active-low);
//        in_valid/in_ready/in_addr/in_data/in_last - host image-word stream;
//        sw_out/load_pc_btn/deposit_btn/run_sw - front-panel drive;
//        halted (CPU), busy/done (loader status);
//        mem_finished/read_enable/write_enable/fetch_state/mem_addr/mem_rdata/mem_wdata - bus observation;
//        tr_valid/tr_ready/tr_type/tr_addr/tr_data/tr_overflow - trace stream.
module panel_loader
  import panel_loader_pkg::*;
#(
  parameter int                WORD_W      = 12,
  parameter int                HOLD_CYC    = 10,
  parameter int                TRACE_DEPTH = 16,
  parameter logic [WORD_W-1:0] START_PC    = DEFAULT_START_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_addr,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic [WORD_W-1:0] sw_out,
  output logic              load_pc_btn,
  output logic              deposit_btn,
  output logic              run_sw,
  input  logic              halted,
  output logic              busy,
  output logic              done,
  input  logic              mem_finished,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic              fetch_state,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [1:0]        tr_type,
  output logic [WORD_W-1:0] tr_addr,
  output logic [WORD_W-1:0] tr_data,
  output logic              tr_overflow
);

  localparam int         TW      = 2 + 2 * WORD_W;
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYC - 1);

  state_t            state;
  state_t            state_n;
  logic [7:0]        cnt;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic              last_q;
  logic              phase_end;

  logic              fin_q;
  logic              trace_ev;
  logic              wr_pend;
  logic [WORD_W-1:0] pend_addr;
  logic [WORD_W-1:0] pend_data;
  logic              push;
  logic [TW-1:0]     push_data;
  logic [TW-1:0]     head;
  logic              empty;

  assign phase_end = (cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (in_valid)  state_n = S_ADDR_SET;
      S_ADDR_SET: if (phase_end) state_n = S_LPC_HI;
      S_LPC_HI:   if (phase_end) state_n = S_LPC_LO;
      S_LPC_LO:   if (phase_end) state_n = S_DATA_SET;
      S_DATA_SET: if (phase_end) state_n = S_DEP_HI;
      S_DEP_HI:   if (phase_end) state_n = S_DEP_LO;
      S_DEP_LO:   if (phase_end) state_n = last_q ? S_PC_SET : S_IDLE;
      S_PC_SET:   if (phase_end) state_n = S_PC_HI;
      S_PC_HI:    if (phase_end) state_n = S_PC_LO;
      S_PC_LO:    if (phase_end) state_n = S_RUN;
      S_RUN:      if (halted)    state_n = S_DONE;
      S_DONE:     state_n = S_DONE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Output logic; purely from state so an async reset releases buttons at once.
  always_comb begin
    sw_out      = '0;
    load_pc_btn = 1'b0;
    deposit_btn = 1'b0;
    run_sw      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    in_ready    = 1'b0;
    case (state)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
      end
      S_ADDR_SET, S_LPC_LO: sw_out = addr_q;
      S_LPC_HI: begin
        sw_out      = addr_q;
        load_pc_btn = 1'b1;
      end
      S_DATA_SET, S_DEP_LO: sw_out = data_q;
      S_DEP_HI: begin
        sw_out      = data_q;
        deposit_btn = 1'b1;
      end
      S_PC_SET, S_PC_LO: sw_out = START_PC;
      S_PC_HI: begin
        sw_out      = START_PC;
        load_pc_btn = 1'b1;
      end
      S_RUN: run_sw = 1'b1;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // One down-counter times every hold phase; it reloads on any state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (state_n != state) cnt <= HOLD_LD;
    else if (!phase_end)       cnt <= cnt - 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      addr_q <= in_addr;
      data_q <= in_data;
      last_q <= in_last;
    end
  end

  // Bus observation: a dual read+write transfer queues its write entry for the
  // following clock. A new rising edge cannot arrive that soon, so they never collide.
  assign trace_ev = mem_finished && !fin_q && (state == S_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fin_q     <= 1'b0;
      wr_pend   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      fin_q   <= mem_finished;
      wr_pend <= trace_ev && read_enable && write_enable;
      if (trace_ev) begin
        pend_addr <= mem_addr;
        pend_data <= mem_wdata;
      end
    end
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (wr_pend) begin
      push      = 1'b1;
      push_data = {TR_WRITE, pend_addr, pend_data};
    end else if (trace_ev && read_enable) begin
      push      = 1'b1;
      push_data = {fetch_state ? TR_FETCH : TR_READ, mem_addr, mem_rdata};
    end else if (trace_ev && write_enable) begin
      push      = 1'b1;
      push_data = {TR_WRITE, mem_addr, mem_wdata};
    end
  end

  trace_fifo #(
    .WIDTH (TW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (tr_valid && tr_ready),
    .head      (head),
    .empty     (empty),
    .overflow  (tr_overflow)
  );

  assign tr_valid = !empty;
  assign tr_type  = head[TW-1 -: 2];
  assign tr_addr  = head[2*WORD_W-1 -: WORD_W];
  assign tr_data  = head[WORD_W-1:0];

endmodule
